// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage.
// Divide/remainder support is compiled only when EX_DIV_EN is defined.
package ex_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [4:0] {
      OP_NOP  = 5'd0,
      OP_ADD  = 5'd1,
      OP_SUB  = 5'd2,
      OP_AND  = 5'd3,
      OP_OR   = 5'd4,
      OP_XOR  = 5'd5,
      OP_SLL  = 5'd6,
      OP_SRL  = 5'd7,
      OP_ADDI = 5'd8,
      OP_MUL  = 5'd9,
      OP_DIV  = 5'd10,
      OP_REM  = 5'd11
   } ex_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } ex_state_e;

   // Quotient returned for a divide by zero.
   localparam logic [DATA_W-1:0] DIV0_Q = '1;

endpackage

// File: rtl/ex_if.sv
// ID/EX -> EX -> EX/MEM bundle. Handshake: an instruction is taken on a rising
// edge where in_valid=1 and stall_o=0; while stall_o=1 the producer holds every input.
interface ex_if #(parameter int W = ex_pkg::DATA_W);
   logic         in_valid;
   logic [4:0]   op_i;
   logic [W-1:0] rd_i;
   logic [W-1:0] rs_i;
   logic [W-1:0] rt_i;
   logic [W-1:0] rsi_i;
   logic         stall_o;
   logic         out_valid;
   logic [4:0]   op_o;
   logic [W-1:0] rd_o;
   logic [W-1:0] result_o;
   logic         zero_o;
   logic         illegal_o;

   modport master (
      output in_valid, op_i, rd_i, rs_i, rt_i, rsi_i,
      input  stall_o, out_valid, op_o, rd_o, result_o, zero_o, illegal_o
   );

   modport slave (
      input  in_valid, op_i, rd_i, rs_i, rt_i, rsi_i,
      output stall_o, out_valid, op_o, rd_o, result_o, zero_o, illegal_o
   );
endinterface

// File: rtl/ex_iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider (DATA_W steps per operation).
// Divide/remainder datapath present only when EX_DIV_EN is defined.
module ex_iter_muldiv
   import ex_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CW = $clog2(DATA_W);

   logic              busy_q;
   logic [CW-1:0]     count_q;
   logic [4:0]        op_q;
   // MUL: acc=partial product, x=multiplicand, y=multiplier.
   // DIV/REM: acc=partial remainder, x=dividend shifting into quotient, y=divisor.
   logic [DATA_W-1:0] acc_q, x_q, y_q;
   logic [DATA_W-1:0] acc_d, x_d, y_d;
`ifdef EX_DIV_EN
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   rem_diff;
`endif

   always_comb begin
      acc_d = acc_q;
      x_d   = x_q;
      y_d   = y_q;
`ifdef EX_DIV_EN
      rem_sh   = '0;
      rem_diff = '0;
`endif
      if (op_q == OP_MUL) begin
         acc_d = y_q[0] ? acc_q + x_q : acc_q;
         x_d   = x_q << 1;
         y_d   = y_q >> 1;
      end
`ifdef EX_DIV_EN
      else begin
         rem_sh   = {acc_q, x_q[DATA_W-1]};
         rem_diff = rem_sh - {1'b0, y_q};
         x_d      = {x_q[DATA_W-2:0], 1'b0};
         if (rem_sh >= {1'b0, y_q}) begin
            acc_d  = rem_diff[DATA_W-1:0];
            x_d[0] = 1'b1;
         end else begin
            acc_d = rem_sh[DATA_W-1:0];
         end
      end
`endif
   end

   assign done = busy_q && (count_q == CW'(DATA_W - 1));

   // Result reflects the final step, so it is valid in the same cycle as done.
   always_comb begin
      result = acc_d;
`ifdef EX_DIV_EN
      if (op_q == OP_DIV) result = (y_q == '0) ? DIV0_Q : x_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         count_q <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else if (start) begin
         busy_q  <= 1'b1;
         count_q <= '0;
         op_q    <= op;
         acc_q   <= '0;
         x_q     <= a;
         y_q     <= b;
      end else if (busy_q) begin
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         count_q <= count_q + 1'b1;
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL (and DIV/REM with EX_DIV_EN)
// that stalls upstream. state_o exposes the FSM for observation.
module ex_stage
   import ex_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   ex_if.slave       bus,
   output ex_state_e state_o
);

   ex_state_e         state_q, state_d;
   logic              stall_q, stall_d;
   logic              vld_q, vld_d;
   logic [4:0]        op_q, op_d, pend_op_q, pend_op_d;
   logic [DATA_W-1:0] rd_q, rd_d, pend_rd_q, pend_rd_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              zero_q, zero_d;
   logic              ill_q, ill_d;

   logic              accept, iter, alu_ill, start, md_done;
   logic [DATA_W-1:0] alu_res, md_res;

   assign accept = bus.in_valid && !stall_q;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      iter    = 1'b0;
      case (bus.op_i)
         OP_NOP:  ;
         OP_ADD:  alu_res = bus.rs_i + bus.rt_i;
         OP_SUB:  alu_res = bus.rs_i - bus.rt_i;
         OP_AND:  alu_res = bus.rs_i & bus.rt_i;
         OP_OR:   alu_res = bus.rs_i | bus.rt_i;
         OP_XOR:  alu_res = bus.rs_i ^ bus.rt_i;
         OP_SLL:  alu_res = bus.rs_i << bus.rt_i[4:0];
         OP_SRL:  alu_res = bus.rs_i >> bus.rt_i[4:0];
         OP_ADDI: alu_res = bus.rs_i + bus.rsi_i;
         OP_MUL:  iter = 1'b1;
`ifdef EX_DIV_EN
         OP_DIV, OP_REM: iter = 1'b1;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   ex_iter_muldiv u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (bus.op_i),
      .a      (bus.rs_i),
      .b      (bus.rt_i),
      .done   (md_done),
      .result (md_res)
   );

   always_comb begin
      state_d   = state_q;
      stall_d   = stall_q;
      vld_d     = 1'b0;
      op_d      = op_q;
      rd_d      = rd_q;
      res_d     = res_q;
      zero_d    = zero_q;
      ill_d     = ill_q;
      pend_op_d = pend_op_q;
      pend_rd_d = pend_rd_q;
      start     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && iter) begin
               start     = 1'b1;
               state_d   = BUSY;
               stall_d   = 1'b1;
               pend_op_d = bus.op_i;
               pend_rd_d = bus.rd_i;
            end else if (accept && bus.op_i != OP_NOP) begin
               vld_d  = 1'b1;
               op_d   = bus.op_i;
               rd_d   = bus.rd_i;
               res_d  = alu_res;
               zero_d = (alu_res == '0);
               ill_d  = alu_ill;
            end
         end
         BUSY: begin
            if (md_done) begin
               state_d = IDLE;
               stall_d = 1'b0;
               vld_d   = 1'b1;
               op_d    = pend_op_q;
               rd_d    = pend_rd_q;
               res_d   = md_res;
               zero_d  = (md_res == '0);
               ill_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            stall_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         stall_q   <= 1'b0;
         vld_q     <= 1'b0;
         op_q      <= '0;
         rd_q      <= '0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         ill_q     <= 1'b0;
         pend_op_q <= '0;
         pend_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         stall_q   <= stall_d;
         vld_q     <= vld_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         res_q     <= res_d;
         zero_q    <= zero_d;
         ill_q     <= ill_d;
         pend_op_q <= pend_op_d;
         pend_rd_q <= pend_rd_d;
      end
   end

   assign bus.stall_o   = stall_q;
   assign bus.out_valid = vld_q;
   assign bus.op_o      = op_q;
   assign bus.rd_o      = rd_q;
   assign bus.result_o  = res_q;
   assign bus.zero_o    = zero_q;
   assign bus.illegal_o = ill_q;
   assign state_o       = state_q;

endmodule
